// File: rtl/io_bridge_pkg.sv
// Shared constants for io_bridge: I/O window select, register offsets,
// read-return select encoding and a byte-lane helper.
package io_bridge_pkg;

  localparam logic [1:0] IO_BASE_SEL = 2'b11;
  localparam logic [2:0] IO_UART     = 3'h0;
  localparam logic [2:0] IO_CLK      = 3'h4;

  typedef enum logic {
    SEL_RAM = 1'b0,
    SEL_IO  = 1'b1
  } sel_t;

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] k);
    return word[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/io_bridge_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head is presented combinationally.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wptr;
  logic [DEPTH_LOG2:0] r_rptr;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                     (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rptr[DEPTH_LOG2-1:0]];

  // Pointer advance; reset empties the FIFO and discards its contents.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage write.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/io_bridge.sv
// CPU bus bridge: routes byte accesses to RAM or to memory-mapped UART FIFOs,
// cycle counter and program stop, and stalls the CPU via cpu_rdy.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int RAM_AW         = 17,
  parameter int IN_DEPTH_LOG2  = 4,
  parameter int OUT_DEPTH_LOG2 = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [31:0]       cpu_a,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_din,
  output logic              cpu_rdy,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              halt
);

  logic        w_io;
  logic        w_hi_zero;
  logic [2:0]  w_off;
  logic        w_rd_uart;
  logic        w_rd_clk;
  logic        w_wr_uart;
  logic        w_wr_clk;
  logic        w_nz;
  logic        w_in_full;
  logic        w_in_empty;
  logic [7:0]  w_in_head;
  logic        w_out_full;
  logic        w_out_empty;
  logic        w_out_push;
  logic [7:0]  w_out_wdata;
  logic        w_tx_hs;
  logic [7:0]  w_io_byte;
  logic        w_unused_hi;

  sel_t        r_sel_q;
  logic [7:0]  r_io_q;
  logic [31:0] r_counter;
  logic [31:0] r_snapshot;
  logic        r_halt_pend;
  logic        r_halt;

  assign w_unused_hi = |cpu_a[31:18];

  assign w_io      = (cpu_a[17:16] == IO_BASE_SEL);
  assign w_hi_zero = (cpu_a[15:3] == 13'h0000);
  assign w_off     = cpu_a[2:0];
  assign w_rd_uart = w_io & ~cpu_wr & w_hi_zero & (w_off == IO_UART);
  assign w_rd_clk  = w_io & ~cpu_wr & w_hi_zero & ((w_off & 3'b100) == IO_CLK);
  assign w_wr_uart = w_io &  cpu_wr & w_hi_zero & (w_off == IO_UART);
  assign w_wr_clk  = w_io &  cpu_wr & w_hi_zero & (w_off == IO_CLK);
  assign w_nz      = (cpu_dout != 8'h00);

  // Stall terms use full/empty before any same-cycle push or pop.
  assign cpu_rdy = rst_in & ~r_halt_pend
                 & ~(w_rd_uart & w_in_empty)
                 & ~(w_wr_uart & w_nz & w_out_full)
                 & ~(w_wr_clk & w_out_full);

  assign ram_a     = cpu_a[RAM_AW-1:0];
  assign ram_wdata = cpu_dout;
  assign ram_we    = cpu_wr & ~w_io & cpu_rdy;

  assign rx_ready    = ~w_in_full;
  assign tx_valid    = ~w_out_empty;
  assign w_tx_hs     = tx_valid & tx_ready;
  assign w_out_push  = cpu_rdy & ((w_wr_uart & w_nz) | w_wr_clk);
  assign w_out_wdata = w_wr_clk ? 8'h00 : cpu_dout;

  assign cpu_din = (r_sel_q == SEL_RAM) ? ram_rdata : r_io_q;
  assign halt    = r_halt;

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(IN_DEPTH_LOG2)) u_in_fifo (
    .i_clk   (clk_in),
    .i_rst_n (rst_in),
    .i_push  (rx_valid),
    .i_wdata (rx_data),
    .i_pop   (w_rd_uart & cpu_rdy),
    .o_head  (w_in_head),
    .o_full  (w_in_full),
    .o_empty (w_in_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(OUT_DEPTH_LOG2)) u_out_fifo (
    .i_clk   (clk_in),
    .i_rst_n (rst_in),
    .i_push  (w_out_push),
    .i_wdata (w_out_wdata),
    .i_pop   (w_tx_hs),
    .o_head  (tx_data),
    .o_full  (w_out_full),
    .o_empty (w_out_empty)
  );

  // I/O read byte: k=0 of the clock register reads live, k=1..3 read the snapshot.
  always_comb begin
    w_io_byte = 8'h00;
    if (w_rd_uart) begin
      w_io_byte = w_in_head;
    end else if (w_rd_clk && (w_off[1:0] == 2'b00)) begin
      w_io_byte = r_counter[7:0];
    end else if (w_rd_clk) begin
      w_io_byte = byte_of(r_snapshot, w_off[1:0]);
    end else begin
      w_io_byte = 8'h00;
    end
  end

  // Read-return select, counter, snapshot and halt sequencing.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_sel_q     <= SEL_RAM;
      r_io_q      <= 8'h00;
      r_counter   <= 32'h0000_0000;
      r_snapshot  <= 32'h0000_0000;
      r_halt_pend <= 1'b0;
      r_halt      <= 1'b0;
    end else begin
      if (cpu_rdy) begin
        r_sel_q <= w_io ? SEL_IO : SEL_RAM;
        r_io_q  <= w_io_byte;
        if (w_rd_clk && (w_off[1:0] == 2'b00)) r_snapshot <= r_counter;
        if (w_wr_clk) r_halt_pend <= 1'b1;
      end
      if (!r_halt) r_counter <= r_counter + 32'd1;
      if (r_halt_pend && w_out_empty && !w_tx_hs) r_halt <= 1'b1;
    end
  end

endmodule
